// File: rtl/aes_job_arbiter.sv
// aes_job_arbiter
//
// Shares one AES-256 encrypt core among NUM_REQ requesters. Only one job is
// in flight at a time. A round-robin grant picks a requester in IDLE, its
// plaintext and key are latched toward the core, a one-cycle start strobe is
// issued, and the ciphertext is returned to the requester tagged with its ID.
//
// Optional build macro: AES_ARB_TIMEOUT_EN
//   defined   : watchdog in WAIT; after TIMEOUT_CYCLES without core_valid the
//               job completes with resp_err = 1 and resp_data = 0
//   undefined : no watchdog, WAIT lasts until core_valid, resp_err tied to 0
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     per-requester request handshake (ready one-hot/0)
//   req_data, req_key       packed plaintexts (128b each) and keys (256b each)
//   resp_valid/resp_ready   result handshake
//   resp_id, resp_data      owning requester and ciphertext
//   resp_err                job aborted by watchdog
//   core_start              one-cycle start strobe to the core
//   core_data_in, core_key  latched job operands, stable until next job
//   core_data_out, core_valid  core result
//   busy                    high in any state other than IDLE
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational
// ISSUE | operands latched; core_start high for this cycle only
// WAIT  | waiting for core_valid (or watchdog expiry)
// RESP  | result presented until resp_ready

module aes_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*128-1:0] req_data,
    input  logic [NUM_REQ*256-1:0] req_key,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [127:0]           resp_data,
    output logic                   resp_err,
    output logic                   core_start,
    output logic [127:0]           core_data_in,
    output logic [255:0]           core_key,
    input  logic [127:0]           core_data_out,
    input  logic                   core_valid,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] grant;
    logic            grant_vld;
    logic [127:0]    sel_data;
    logic [255:0]    sel_key;
    logic            timeout_hit;
    int              rank;
    int              best_rank;

    // Round-robin grant: rank each requester by its distance after
    // last_grant (wrapping) and take the lowest-ranked valid one.
    always_comb begin
        grant     = '0;
        rank      = 0;
        best_rank = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i > int'(last_grant))
                rank = i - int'(last_grant) - 1;
            else
                rank = i + NUM_REQ - int'(last_grant) - 1;
            if (req_valid[i] && (rank < best_rank)) begin
                best_rank = rank;
                grant     = ID_W'(i);
            end
        end
        grant_vld = |req_valid;
    end

    always_comb begin
        sel_data  = '0;
        sel_key   = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_data = req_data[128*i +: 128];
                sel_key  = req_key[256*i +: 256];
            end
            // Gated by rst_n so no requester sees an accept that the
            // synchronous reset is about to discard.
            req_ready[i] = rst_n && (state == IDLE) && grant_vld && (grant == ID_W'(i));
        end
    end

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Down-counter loaded in ISSUE; terminal count zero marks the last
    // allowed WAIT cycle, so WAIT lasts exactly TIMEOUT_CYCLES cycles.
    logic [CNT_W-1:0] wd_cnt;

    assign timeout_hit = (state == WAIT) && (wd_cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt   <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state == ISSUE)
                wd_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
            else if ((state == WAIT) && (wd_cnt != '0))
                wd_cnt <= wd_cnt - CNT_W'(1);

            // core_valid on the terminal cycle takes precedence.
            if (state == WAIT) begin
                if (core_valid)
                    resp_err <= 1'b0;
                else if (timeout_hit)
                    resp_err <= 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
    assign resp_err    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (core_valid || timeout_hit) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            last_grant   <= ID_W'(NUM_REQ - 1);
            core_data_in <= '0;
            core_key     <= '0;
            resp_id      <= '0;
            resp_data    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        core_data_in <= sel_data;
                        core_key     <= sel_key;
                        resp_id      <= grant;
                        last_grant   <= grant;
                    end
                end
                WAIT: begin
                    if (core_valid)
                        resp_data <= core_data_out;
                    else if (timeout_hit)
                        resp_data <= '0;
                end
                default: ;
            endcase
        end
    end

    assign core_start = (state == ISSUE);
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_aes_job_arbiter.sv
module tb_aes_job_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int TB_TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_data;
    logic [NUM_REQ*256-1:0] req_key;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [127:0]           resp_data;
    logic                   resp_err;
    logic                   core_start;
    logic [127:0]           core_data_in;
    logic [255:0]           core_key;
    logic [127:0]           core_data_out;
    logic                   core_valid;
    logic                   busy;

    aes_job_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .ID_W          (ID_W),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_key      (req_key),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .core_start   (core_start),
        .core_data_in (core_data_in),
        .core_key     (core_key),
        .core_data_out(core_data_out),
        .core_valid   (core_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    int n_pass   = 0;
    int n_checks = 0;
    int last_g;            // reference model: last granted requester
    int obs_id;            // resp_id seen for the most recent job
    int rr_exp[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin rule: first valid requester after last_g, wrapping.
    function automatic int rr_pick(input logic [NUM_REQ-1:0] mask);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (last_g + k) % NUM_REQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    // Stand-in for the encrypt core: the real FIPS-197 answer for the
    // reference vector, an arbitrary mixing function otherwise.
    function automatic logic [127:0] fake_core(input logic [127:0] d, input logic [255:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ k[127:0] ^ {k[191:128], k[255:192]} ^ 128'h5a5a_0f0f_a5a5_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[128*i +: 128] = rand128();
            req_key[256*i +: 256]  = {rand128(), rand128()};
        end
    endtask

    // One job from grant to response handshake. Entered with the DUT in IDLE
    // and req_valid/req_data/req_key already driven. lat < 0 means the core
    // never answers and the watchdog must close the job.
    task automatic do_job(input int lat, input int bp, input bit spur, input bit drop_valid);
        int                 g;
        logic [NUM_REQ-1:0] exp_rdy;
        logic [127:0]       d;
        logic [255:0]       k;
        logic [127:0]       exp_ct;
        logic               exp_err;
        g = rr_pick(req_valid);
        exp_rdy = '0;
        exp_rdy[g] = 1'b1;
        d = req_data[128*g +: 128];
        k = req_key[256*g +: 256];
        #1;
        chk("idle_req_ready", req_ready, exp_rdy);
        chk("idle_busy", busy, 1'b0);
        tick();
        last_g = g;
        chk("issue_start", core_start, 1'b1);
        chk("issue_data", core_data_in, d);
        chk("issue_key", core_key, k);
        chk("issue_req_ready", req_ready, '0);
        chk("issue_busy", busy, 1'b1);
        if (spur) begin
            core_valid    = 1'b1;
            core_data_out = rand128();
        end
        if (drop_valid) req_valid[g] = 1'b0;
        tick();
        core_valid = 1'b0;
        chk("wait_start_low", core_start, 1'b0);
        chk("wait_no_resp", resp_valid, 1'b0);
        if (lat < 0) begin
            repeat (TB_TIMEOUT - 1) tick();
            chk("wait_before_timeout", resp_valid, 1'b0);
            tick();
            exp_ct  = '0;
            exp_err = 1'b1;
        end else begin
            repeat (lat) tick();
            chk("wait_no_resp_late", resp_valid, 1'b0);
            chk("wait_data_held", core_data_in, d);
            chk("wait_key_held", core_key, k);
            core_valid    = 1'b1;
            core_data_out = fake_core(d, k);
            tick();
            core_valid    = 1'b0;
            core_data_out = rand128();
            exp_ct  = fake_core(d, k);
            exp_err = 1'b0;
        end
        chk("resp_valid", resp_valid, 1'b1);
        chk("resp_id", resp_id, g);
        chk("resp_data", resp_data, exp_ct);
        chk("resp_err", resp_err, exp_err);
        obs_id = int'(resp_id);
        for (int c = 0; c < bp; c++) begin
            tick();
            chk("bp_valid", resp_valid, 1'b1);
            chk("bp_id", resp_id, g);
            chk("bp_data", resp_data, exp_ct);
            chk("bp_req_ready", req_ready, '0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("post_resp_valid", resp_valid, 1'b0);
        chk("post_resp_busy", busy, 1'b0);
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        req_key       = '0;
        resp_ready    = 1'b0;
        core_data_out = '0;
        core_valid    = 1'b0;
        last_g        = NUM_REQ - 1;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_id", resp_id, '0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_data", core_data_in, '0);
        chk("rst_core_key", core_key, '0);

        // Spurious core_valid in IDLE
        core_valid    = 1'b1;
        core_data_out = rand128();
        tick();
        core_valid = 1'b0;
        chk("spur_idle_busy", busy, 1'b0);
        chk("spur_idle_resp", resp_valid, 1'b0);

        // FIPS-197 vector on requester 2, spurious core_valid during ISSUE
        fill_random();
        req_data[128*2 +: 128] = FIPS_PT;
        req_key[256*2 +: 256]  = FIPS_KEY;
        req_valid = 4'b0100;
        do_job(3, 0, 1'b1, 1'b1);
        req_valid = '0;

        // Reset during WAIT drops the job
        fill_random();
        req_valid = 4'b1010;
        tick();
        tick();
        tick();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        #1;
        last_g = NUM_REQ - 1;
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_resp_valid", resp_valid, 1'b0);
        chk("rstw_resp_data", resp_data, '0);
        chk("rstw_resp_id", resp_id, '0);
        chk("rstw_core_start", core_start, 1'b0);
        chk("rstw_core_data", core_data_in, '0);
        chk("rstw_core_key", core_key, '0);
        chk("rstw_req_ready", req_ready, '0);

        // Round-robin with everyone requesting: 0,1,2,3,0
        req_valid = 4'hF;
        for (int j = 0; j < 5; j++) begin
            fill_random();
            do_job($urandom_range(0, 4), 0, 1'b0, 1'b0);
            chk("rr_order", obs_id, rr_exp[j]);
        end

        // Backpressure for 20 cycles
        fill_random();
        req_valid = 4'b0110;
        do_job(2, 20, 1'b0, 1'b0);

        // Core answers on the last allowed WAIT cycle
        fill_random();
        req_valid = 4'b1001;
        do_job(TB_TIMEOUT - 1, 1, 1'b0, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 12; j++) begin
            fill_random();
            req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            do_job($urandom_range(0, 10), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef AES_ARB_TIMEOUT_EN
        // Core never answers: watchdog closes the job
        fill_random();
        req_valid = 4'b0011;
        do_job(-1, 2, 1'b0, 1'b0);
        fill_random();
        req_valid = 4'b1100;
        do_job(-1, 0, 1'b1, 1'b1);
`endif

        req_valid = '0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
